pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/bubble/flush controller for the 5-stage pipeline (F, D, E, M, W).
- Drives the per-register enable and sendNop-style bubble inputs of every pipeline register, including the E/M ALU register.
- Resolves load-use hazards, taken branches resolved in M, multi-cycle multiply in E, and instruction and data memory miss waits.
- Holds a small FSM plus a multiply latency counter.

Parameters:
MUL_LAT, 4, total cycles a multiply occupies E; legal range 2..15.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rsD  in  5  source reg rs of instruction in D
rtD  in  5  source reg rt of instruction in D
writeregE  in  5  destination reg of instruction in E
memtoregE  in  1  instruction in E is a load
branch_takenM  in  1  branch in M resolved taken
mul_startE  in  1  multiply entered E this cycle
dmiss  in  1  data memory miss for instruction in M (level)
dready  in  1  data miss serviced (1-cycle pulse)
imiss  in  1  instruction fetch miss (level)
iready  in  1  fetch miss serviced (1-cycle pulse)
enF, enD, enE, enM, enW  out  1 each  load enables: PC, F/D, D/E, E/M, M/W registers
nopD, nopE, nopM, nopW  out  1 each  bubble into F/D, D/E, E/M, M/W registers (valid only with matching en=1)
state  out  2  FSM state for debug

Behaviour:
- FSM states: RUN=0, DWAIT=1, MULWAIT=2, IWAIT=3. The state register and the 4-bit counter cnt are the only sequential elements.
- reset=1 (async): state=RUN, cnt=0. All en*=0 and all nop*=0, gated combinationally while reset is high.
- Outputs are combinational from state, cnt and inputs, so a stall takes effect in the same cycle.
- RUN priority, highest first:
  1. dmiss: enF=enD=enE=enM=0, enW=1, nopW=1. Next state DWAIT.
  2. mul_startE: enF=enD=enE=0, enM=1, nopM=1. cnt<=MUL_LAT-1. Next state MULWAIT.
  3. branch_takenM: all en=1, nopD=nopE=nopM=1 (squash 3 younger instructions). Stay in RUN.
  4. Load-use hazard, defined as memtoregE && writeregE!=0 && (writeregE==rsD || writeregE==rtD): enF=enD=0, enE=enM=enW=1, nopE=1. Stay in RUN.
  5. imiss: enF=0, enD=enE=enM=enW=1, nopD=1. Next state IWAIT.
  6. Otherwise all en=1, all nop=0.
- DWAIT:
  - dready=0: repeat the rule-1 outputs.
  - dready=1: go to RUN and evaluate RUN rules 2..6 in the same cycle (dmiss ignored that cycle).
- MULWAIT:
  - cnt>1: cnt<=cnt-1 and repeat the rule-2 outputs (a bubble into M each cycle).
  - cnt==1: go to RUN and evaluate RUN rules 1..6 with mul_startE ignored.
  - Net effect: the multiply holds E for exactly MUL_LAT cycles, with MUL_LAT-1 bubbles entering M.
- IWAIT:
  - iready=0: enF=0, nopD=1, remaining en=1.
  - iready=1: evaluate RUN rules 1..6 and go to the resulting state.
  - dmiss or branch_takenM while in IWAIT: apply that rule immediately. dmiss moves to DWAIT; the fetch miss is re-sampled via the imiss level afterwards.
- writeregE==0 never creates a load-use hazard.
- Reset asserted mid-wait aborts it: state=RUN, cnt=0 asynchronously.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, adds outputs stall_cycles[31:0] and flush_count[15:0]. Both reset to 0.
  - stall_cycles increments every cycle with enF=0 and reset=0.
  - flush_count increments on each cycle where rule 3 fires.
  - Both saturate at all-ones.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Load-use: memtoregE=1, writeregE=5, rsD=5 -> one cycle of enF=enD=0, nopE=1; same with writeregE=0 -> no stall.
- Multiply, MUL_LAT=4: pulse mul_startE -> enE=0 and nopM=1 for 3 consecutive cycles, then all en=1 with state=RUN on cycle 4.
- Data miss: dmiss=1 held 5 cycles, then dready pulse -> enF..enM=0 and nopW=1 for 5 cycles. state=1 during the wait, RUN on the dready cycle.
- Branch with simultaneous load-use: branch_takenM=1 with the hazard conditions present -> flush wins: nopD=nopE=nopM=1, all en=1, no stall.
- Instruction miss interrupted by data miss: imiss=1 (IWAIT), then dmiss=1 -> state=DWAIT the next cycle; after dready with imiss still 1 -> state=IWAIT.
- Async reset during MULWAIT with cnt=2 -> state=0 and all outputs 0 immediately, without waiting for a clk edge. With PIPE_PERF_CNT_EN, counters also read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and pipeline-register control outputs of the stall/flush controller
// Optional PIPE_PERF_CNT_EN adds the stall_cycles/flush_count performance outputs.
interface pipe_hazard_ctrl_if;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic [4:0] writeregE;
    logic       memtoregE;
    logic       branch_takenM;
    logic       mul_startE;
    logic       dmiss;
    logic       dready;
    logic       imiss;
    logic       iready;
    logic       enF;
    logic       enD;
    logic       enE;
    logic       enM;
    logic       enW;
    logic       nopD;
    logic       nopE;
    logic       nopM;
    logic       nopW;
    logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    modport master (
        output rsD, rtD, writeregE, memtoregE, branch_takenM, mul_startE,
               dmiss, dready, imiss, iready,
        input  enF, enD, enE, enM, enW, nopD, nopE, nopM, nopW, state
`ifdef PIPE_PERF_CNT_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  rsD, rtD, writeregE, memtoregE, branch_takenM, mul_startE,
               dmiss, dready, imiss, iready,
        output enF, enD, enE, enM, enW, nopD, nopE, nopM, nopW, state
`ifdef PIPE_PERF_CNT_EN
        , output stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/flush controller for the 5-stage pipeline (optional PIPE_PERF_CNT_EN perf counters)
// The state output shows RUN during a cycle in which a wait ends and the RUN rules are evaluated.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4
) (
    input logic              clk,
    input logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, MULWAIT = 2'd2, IWAIT = 2'd3} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] en;
    logic [3:0] nop;
    logic       eval_run, ign_d, ign_m, hazard, flush;

    assign hazard = bus.memtoregE && (bus.writeregE != 5'd0) &&
                    ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD));

    // Wait-state handling, then the prioritised RUN rules when a wait ends or in RUN
    always_comb begin
        en       = 5'b11111;
        nop      = 4'b0000;
        state_d  = state_q;
        cnt_d    = cnt_q;
        eval_run = 1'b0;
        ign_d    = 1'b0;
        ign_m    = 1'b0;
        flush    = 1'b0;
        case (state_q)
            RUN: eval_run = 1'b1;
            DWAIT: begin
                if (bus.dready) begin
                    eval_run = 1'b1;
                    ign_d    = 1'b1;
                end else begin
                    en  = 5'b00001;
                    nop = 4'b0001;
                end
            end
            MULWAIT: begin
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                    en    = 5'b00011;
                    nop   = 4'b0010;
                end else begin
                    eval_run = 1'b1;
                    ign_m    = 1'b1;
                end
            end
            IWAIT: begin
                if (bus.iready || bus.dmiss || bus.branch_takenM) begin
                    eval_run = 1'b1;
                end else begin
                    en  = 5'b01111;
                    nop = 4'b1000;
                end
            end
            default: eval_run = 1'b1;
        endcase
        if (eval_run) begin
            state_d = RUN;
            if (bus.dmiss && !ign_d) begin
                en      = 5'b00001;
                nop     = 4'b0001;
                state_d = DWAIT;
            end else if (bus.mul_startE && !ign_m) begin
                en      = 5'b00011;
                nop     = 4'b0010;
                cnt_d   = 4'(MUL_LAT - 1);
                state_d = MULWAIT;
            end else if (bus.branch_takenM) begin
                nop   = 4'b1110;
                flush = 1'b1;
            end else if (hazard) begin
                en  = 5'b00111;
                nop = 4'b0100;
            end else if (bus.imiss) begin
                en      = 5'b01111;
                nop     = 4'b1000;
                state_d = IWAIT;
            end
        end
    end

    // FSM state and multiply latency counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign {bus.enF, bus.enD, bus.enE, bus.enM, bus.enW} = en & {5{~reset}};
    assign {bus.nopD, bus.nopE, bus.nopM, bus.nopW}      = nop & {4{~reset}};
    assign bus.state = eval_run ? RUN : state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    // Saturating counts of fetch-stall cycles and branch flushes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!en[4] && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (flush && flush_q != '1) flush_q <= flush_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard-driven scenario bench for pipe_hazard_ctrl with MUL_LAT=4
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus ();
    pipe_hazard_ctrl #(.MUL_LAT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [4:0] rs, rt, wr;
        logic ld, br, mul, dm, dr, im, ir;
    } in_t;

    // {enF,enD,enE,enM,enW, nopD,nopE,nopM,nopW}
    localparam logic [8:0] R0 = 9'b11111_0000;
    localparam logic [8:0] R1 = 9'b00001_0001;
    localparam logic [8:0] R2 = 9'b00011_0010;
    localparam logic [8:0] R3 = 9'b11111_1110;
    localparam logic [8:0] R4 = 9'b00111_0100;
    localparam logic [8:0] R5 = 9'b01111_1000;

    logic [10:0] sb[$];
    int checks = 0;
    int failures = 0;

    function automatic in_t mk(input int rs, input int rt, input int wr, input bit ld, input bit br,
                               input bit mul, input bit dm, input bit dr, input bit im, input bit ir);
        in_t x;
        x.rs = 5'(rs); x.rt = 5'(rt); x.wr = 5'(wr);
        x.ld = ld; x.br = br; x.mul = mul; x.dm = dm; x.dr = dr; x.im = im; x.ir = ir;
        return x;
    endfunction

    function automatic logic [10:0] ex(input logic [8:0] r, input logic [1:0] st);
        return {r, st};
    endfunction

    function automatic logic [10:0] obs();
        return {bus.enF, bus.enD, bus.enE, bus.enM, bus.enW,
                bus.nopD, bus.nopE, bus.nopM, bus.nopW, bus.state};
    endfunction

    task automatic drive(input in_t x);
        bus.rsD = x.rs; bus.rtD = x.rt; bus.writeregE = x.wr; bus.memtoregE = x.ld;
        bus.branch_takenM = x.br; bus.mul_startE = x.mul; bus.dmiss = x.dm;
        bus.dready = x.dr; bus.imiss = x.im; bus.iready = x.ir;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        reset = 1'b1;
        drive('0);
        sb.push_back(11'd0);
        #2;
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL reset got=%b want=%b", obs(), e); end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 16'd0) begin
            failures++; $display("FAIL reset_perf got=%0d/%0d want=0/0", bus.stall_cycles, bus.flush_count);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        in_t v[5];
        logic [10:0] e[5];
        logic [10:0] x;
        v = '{mk(5,0,5,1,0,0,0,0,0,0), mk(0,0,0,1,0,0,0,0,0,0), mk(3,7,7,1,0,0,0,0,0,0),
              mk(5,0,5,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0)};
        e = '{ex(R4,0), ex(R0,0), ex(R4,0), ex(R0,0), ex(R0,0)};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(v[i]); sb.push_back(e[i]); #3;
            x = sb.pop_front();
            checks++;
            if (obs() !== x) begin failures++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs(), x); end
        end
    endtask

    task automatic test_mul();
        in_t v[5];
        logic [10:0] e[5];
        logic [10:0] x;
        v = '{mk(0,0,0,0,0,1,0,0,0,0), '0, '0, '0, '0};
        e = '{ex(R2,0), ex(R2,2), ex(R2,2), ex(R0,0), ex(R0,0)};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(v[i]); sb.push_back(e[i]); #3;
            x = sb.pop_front();
            checks++;
            if (obs() !== x) begin failures++; $display("FAIL mul[%0d] got=%b want=%b", i, obs(), x); end
        end
    endtask

    task automatic test_dmiss();
        in_t v[7];
        logic [10:0] e[7];
        logic [10:0] x;
        v = '{mk(0,0,0,0,0,0,1,0,0,0), mk(0,0,0,0,0,0,1,0,0,0), mk(0,0,0,0,0,0,1,0,0,0),
              mk(0,0,0,0,0,0,1,0,0,0), mk(0,0,0,0,0,0,1,0,0,0), mk(0,0,0,0,0,0,0,1,0,0), '0};
        e = '{ex(R1,0), ex(R1,1), ex(R1,1), ex(R1,1), ex(R1,1), ex(R0,0), ex(R0,0)};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); drive(v[i]); sb.push_back(e[i]); #3;
            x = sb.pop_front();
            checks++;
            if (obs() !== x) begin failures++; $display("FAIL dmiss[%0d] got=%b want=%b", i, obs(), x); end
        end
    endtask

    task automatic test_branch();
        in_t v[3];
        logic [10:0] e[3];
        logic [10:0] x;
        v = '{mk(5,0,5,1,1,0,0,0,0,0), mk(0,9,9,1,1,0,0,0,0,0), '0};
        e = '{ex(R3,0), ex(R3,0), ex(R0,0)};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(v[i]); sb.push_back(e[i]); #3;
            x = sb.pop_front();
            checks++;
            if (obs() !== x) begin failures++; $display("FAIL branch[%0d] got=%b want=%b", i, obs(), x); end
        end
    endtask

    task automatic test_imiss_dmiss();
        in_t v[8];
        logic [10:0] e[8];
        logic [10:0] x;
        v = '{mk(0,0,0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,1,0,1,0),
              mk(0,0,0,0,0,0,1,0,1,0), mk(0,0,0,0,0,0,0,1,1,0), mk(0,0,0,0,0,0,0,0,1,0),
              mk(0,0,0,0,0,0,0,0,0,1), '0};
        e = '{ex(R5,0), ex(R5,3), ex(R1,0), ex(R1,1), ex(R5,0), ex(R5,3), ex(R0,0), ex(R0,0)};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); drive(v[i]); sb.push_back(e[i]); #3;
            x = sb.pop_front();
            checks++;
            if (obs() !== x) begin failures++; $display("FAIL imiss_dmiss[%0d] got=%b want=%b", i, obs(), x); end
        end
    endtask

    task automatic test_back_to_back();
        in_t v[6];
        logic [10:0] e[6];
        logic [10:0] x;
        v = '{mk(0,0,0,0,0,1,1,0,0,0), mk(0,0,0,0,0,1,0,1,0,0), '0, '0,
              mk(0,0,0,0,0,0,1,0,0,0), mk(0,0,0,0,0,0,0,1,0,0)};
        e = '{ex(R1,0), ex(R2,0), ex(R2,2), ex(R2,2), ex(R1,0), ex(R0,0)};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive(v[i]); sb.push_back(e[i]); #3;
            x = sb.pop_front();
            checks++;
            if (obs() !== x) begin failures++; $display("FAIL back_to_back[%0d] got=%b want=%b", i, obs(), x); end
        end
    endtask

    task automatic test_reset_mulwait();
        logic [10:0] x;
        @(negedge clk); drive(mk(0,0,0,0,0,1,0,0,0,0)); sb.push_back(ex(R2,0)); #3;
        x = sb.pop_front();
        checks++;
        if (obs() !== x) begin failures++; $display("FAIL rst_mul_enter got=%b want=%b", obs(), x); end
        @(negedge clk); drive('0); sb.push_back(ex(R2,2)); #3;
        x = sb.pop_front();
        checks++;
        if (obs() !== x) begin failures++; $display("FAIL rst_mul_wait got=%b want=%b", obs(), x); end
        @(negedge clk);
        #1 reset = 1'b1;
        sb.push_back(11'd0);
        #1;
        x = sb.pop_front();
        checks++;
        if (obs() !== x) begin failures++; $display("FAIL rst_async got=%b want=%b", obs(), x); end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 16'd0) begin
            failures++; $display("FAIL rst_async_perf got=%0d/%0d want=0/0", bus.stall_cycles, bus.flush_count);
        end
`endif
        #1 reset = 1'b0;
        sb.push_back(ex(R0,0));
        #1;
        x = sb.pop_front();
        checks++;
        if (obs() !== x) begin failures++; $display("FAIL rst_release got=%b want=%b", obs(), x); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_dmiss();
        test_branch();
        test_imiss_dmiss();
        test_back_to_back();
        test_reset_mulwait();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
